// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

    // A one-state prescaler still needs a 1-bit register to stay legal.
    function automatic int unsigned prescale_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enabled-cycle divider: tick is high on the enabled cycle that completes each PRESCALE interval.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0]  Last = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]  OneP = PW'(1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = en & (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + OneP;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with clear, load, wrap/saturate and terminal-count pulse.
// Optional prescaler compiled in with COUNTER_UPDOWN_MOD_PRESCALE_EN.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 2 ** WIDTH,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    // One extra bit keeps MODULUS == 2**WIDTH representable.
    localparam logic [WIDTH:0] MaxW = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] OneW = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   next_w;
    logic [WIDTH-1:0] load_clamped;
    logic             max_hit;
    logic             zero_hit;
    logic             end_hit;
    logic             tick;
    logic             step;
    logic             unused_carry;

`ifdef COUNTER_UPDOWN_MOD_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rstn(rstn),
        .en  (en),
        .clr (clr | load),
        .tick(tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE != 0);
    assign tick            = 1'b1;
`endif

    assign step      = en & tick;
    assign count_ext = {1'b0, count_q};
    assign load_ext  = {1'b0, load_val};
    assign max_hit   = (count_ext == MaxW);
    assign zero_hit  = (count_q == '0);
    assign end_hit   = (up == CNT_DOWN) ? zero_hit : max_hit;

    assign load_clamped = (load_ext > MaxW) ? MaxW[WIDTH-1:0] : load_val;

    always_comb begin
        next_w = count_ext;
        if (!end_hit) begin
            next_w = (up == CNT_UP) ? (count_ext + OneW) : (count_ext - OneW);
        end else begin
            unique case (sat)
                CNT_WRAP: next_w = (up == CNT_UP) ? '0 : MaxW;
                CNT_SAT:  next_w = count_ext;
                default:  next_w = count_ext;
            endcase
        end
    end

    assign unused_carry = next_w[WIDTH];

    // Priority: clr > load > step > hold; tc only survives a step taken at the range end.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (step) begin
            count_d = next_w[WIDTH-1:0];
            tc_d    = end_hit;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign at_max  = max_hit;
    assign at_zero = zero_hit;

endmodule
